sec_display: RTL
================

SEC_DISPLAY -- requirements
Module: sec_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 6000, meaning clocks per digit-scan slot (1 kHz at 6 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, meaning seg and dig are driven active-low when 1 and active-high when 0.
REQ-003 The block SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking is enabled when 1.
REQ-004 The block SHALL have port clk_6m, input, width 1, the single clock; all flops are clocked on its rising edge.
REQ-005 The block SHALL have port xrst, input, width 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port sec_in, input, width 8, the binary seconds count from the upstream counter, synchronous to clk_6m.
REQ-007 The block SHALL have port seg, output, width 7, the segment drives a..g on bits 0..6, registered.
REQ-008 The block SHALL have port dig, output, width 3, the one-hot digit enables, bit0=ones, bit1=tens, bit2=hundreds, registered.
REQ-009 The block SHALL have port bcd, output, width 12, the packed BCD value {hundreds, tens, ones}, registered.
REQ-010 The block SHALL have port busy, output, width 1, which is high while a conversion is in progress.

Function
REQ-011 The block SHALL hold register last_val, the most recently captured sec_in.
REQ-012 The conversion FSM SHALL have states IDLE and SHIFT.
REQ-013 In IDLE, when sec_in != last_val, the FSM SHALL capture sec_in into last_val and the shift register, clear the 4-bit BCD accumulators, set the bit counter to 0 and go to SHIFT.
REQ-014 In SHIFT, on each clock the FSM SHALL add 3 to every BCD nibble that is >= 5, then shift {bcd_acc, shreg} left by 1 (double-dabble).
REQ-015 On the 8th SHIFT clock, the FSM SHALL write the result to bcd and return to IDLE.
REQ-016 bcd SHALL update on the 9th rising edge, counting the capturing edge as the 1st.
REQ-017 busy SHALL be high exactly for the 8 cycles the FSM is in SHIFT.
REQ-018 Changes on sec_in during SHIFT SHALL be ignored; the conversion in flight completes.
REQ-019 After a conversion, IDLE re-compares sec_in with last_val on the next edge; if they differ, a new conversion starts with no idle gap beyond that one cycle.
REQ-020 A wrap of sec_in from 255 to 0 SHALL be treated as an ordinary change, giving bcd = 12'h000.
REQ-021 The bcd range SHALL be 000..255; the hundreds nibble never exceeds 2.
REQ-022 The scan prescaler SHALL count 0..SCAN_DIV-1 and wrap.
REQ-023 At terminal count, the scan prescaler SHALL advance the digit index 2->0->1->2.
REQ-024 At the same edge as the index advance, seg and dig SHALL update together, so no cycle shows a new digit with old segments.
REQ-025 Segment patterns SHALL be the standard 0-9 glyphs, decoded from the bcd nibble of the selected digit.
REQ-026 With BLANK_LZ=1, hundreds SHALL be blanked when it is 0, and tens SHALL be blanked when both hundreds and tens are 0.
REQ-027 The ones digit SHALL never be blanked.
REQ-028 A blanked digit SHALL drive seg all-off while its dig bit is still asserted.
REQ-029 An nibble value above 9 SHALL decode to blank (defensive; unreachable).

Reset
REQ-030 While xrst=0, the block SHALL force last_val=0, bcd=0, busy=0, FSM=IDLE, prescaler=0 and digit index=2.
REQ-031 While xrst=0, seg and dig SHALL be all-off for the chosen polarity (ACTIVE_LOW=1: seg=7'h7F, dig=3'b111).
REQ-032 Reset asserted mid-conversion SHALL abort the conversion; bcd keeps its reset value of 0.
REQ-033 After release, the first prescaler terminal count SHALL select the ones digit, showing "0".

Structure
REQ-034 Package sec_display_pkg SHALL hold the FSM state typedef, the 7-bit glyph constants SEG_0..SEG_9 and SEG_BLANK (active-high form), and the digit-index typedef.
REQ-035 The conversion FSM SHALL be the sub-module bin2bcd8 (ports: clk_6m, xrst, start, bin[7:0], bcd[11:0], busy).
REQ-036 Change detection, the scan prescaler, glyph decode and polarity inversion SHALL live in sec_display.

Verification
REQ-037 The bench SHALL cover: reset, then sec_in held at 0 -> busy never rises, bcd=12'h000, and the scan shows only the ones digit lit with glyph 0; hundreds and tens are blanked.
REQ-038 The bench SHALL cover: sec_in 0->59 at edge N -> busy high for cycles N+1..N+8, and bcd=12'h059 after edge N+8.
REQ-039 The bench SHALL cover: sec_in 254->255 during SHIFT -> the first result is 12'h254, and a second conversion then yields 12'h255.
REQ-040 The bench SHALL cover: sec_in 255->0 -> bcd=12'h000, with tens and hundreds blanked.
REQ-041 The bench SHALL cover: SCAN_DIV=4 with sec_in=105 -> dig cycles ones/tens/hundreds every 4 clocks with glyphs 5, 0 (not blanked) and 1, and seg changes on the same edge as dig.
REQ-042 The bench SHALL cover: xrst pulsed low at SHIFT cycle 4 -> all outputs return to reset values immediately (asynchronously), and no bcd update occurs.

Source files
------------

// File: rtl/sec_display_pkg.sv
// Shared types and segment glyphs for the seconds display.
// Glyphs are active-high, segments a..g on bits 0..6.
package sec_display_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } dig_idx_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// 8-bit binary to 3-digit BCD, serial double-dabble; bcd updates 8 clocks after start.
// No backpressure: start is only honoured in IDLE, busy is high while shifting.
module bin2bcd8
  import sec_display_pkg::*;
(
  input  logic        clk_6m,
  input  logic        xrst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy
);

  conv_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] acc_adj;
  logic [19:0] shifted;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    acc_adj = {dabble_adj(acc_q[11:8]), dabble_adj(acc_q[7:4]), dabble_adj(acc_q[3:0])};
    shifted = {acc_adj, shreg_q} << 1;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = shifted[19:8];
        shreg_d = shifted[7:0];
        cnt_d   = cnt_q + 3'd1;
        // Last shift lands straight in the output register.
        if (cnt_q == 3'd7) begin
          bcd_d   = shifted[19:8];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_6m or negedge xrst) begin
    if (!xrst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: rtl/sec_display.sv
// Seconds value to multiplexed 3-digit 7-segment display; bcd 9 clocks after a change.
// No backpressure: sec_in changes during a conversion are picked up once it finishes.
module sec_display
  import sec_display_pkg::*;
#(
  parameter int SCAN_DIV   = 6000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic        clk_6m,
  input  logic        xrst,
  input  logic [7:0]  sec_in,
  output logic [6:0]  seg,
  output logic [2:0]  dig,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]  DIG_OFF   = ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [7:0]  last_val_q, last_val_d;
  logic [15:0] presc_q, presc_d;
  dig_idx_e    idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  dig_q, dig_d;
  logic        start;
  logic [3:0]  nib;
  logic        blank;
  logic [2:0]  dig_hot;
  logic [6:0]  seg_hi;

  bin2bcd8 u_conv (
    .clk_6m (clk_6m),
    .xrst   (xrst),
    .start  (start),
    .bin    (sec_in),
    .bcd    (bcd),
    .busy   (busy)
  );

  always_comb begin
    start      = !busy && (sec_in != last_val_q);
    last_val_d = start ? sec_in : last_val_q;
    presc_d    = presc_q + 16'd1;
    idx_d      = idx_q;
    seg_d      = seg_q;
    dig_d      = dig_q;
    nib        = '0;
    blank      = 1'b0;
    dig_hot    = '0;
    seg_hi     = SEG_BLANK;
    // Index, segments and enables all move on the same edge to avoid ghosting.
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      case (idx_q)
        DIG_HUND: idx_d = DIG_ONES;
        DIG_ONES: idx_d = DIG_TENS;
        default:  idx_d = DIG_HUND;
      endcase
      case (idx_d)
        DIG_ONES: begin
          nib     = bcd[3:0];
          dig_hot = 3'b001;
        end
        DIG_TENS: begin
          nib     = bcd[7:4];
          blank   = BLANK_LZ && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
          dig_hot = 3'b010;
        end
        default: begin
          nib     = bcd[11:8];
          blank   = BLANK_LZ && (bcd[11:8] == 4'd0);
          dig_hot = 3'b100;
        end
      endcase
      seg_hi = blank ? SEG_BLANK : glyph(nib);
      seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
      dig_d  = ACTIVE_LOW ? ~dig_hot : dig_hot;
    end
  end

  always_ff @(posedge clk_6m or negedge xrst) begin
    if (!xrst) begin
      last_val_q <= '0;
      presc_q    <= '0;
      idx_q      <= DIG_HUND;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      last_val_q <= last_val_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule
